// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer: slot-state encoding and error-counter width.
package stream_demux_pkg;

    localparam logic        SLOT_EMPTY = 1'b0;
    localparam logic        SLOT_FULL  = 1'b1;
    localparam int unsigned ERRCNT_W   = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel; a write and a drain may coincide.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             state_q, state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                data_q <= wr_data;
            end
        end
    end

    // A write wins over a drain so a same-cycle drain and refill leaves the slot full.
    always_comb begin
        state_d = state_q;
        if (wr_en) begin
            state_d = SLOT_FULL;
        end else if (rd_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        valid = (state_q == SLOT_FULL);
        data  = data_q;
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT demultiplexer with valid/ready handshake and one-entry slot per channel.
// Optional saturating out-of-range counter enabled by STREAM_DEMUX_ERRCNT_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned   WIDTH   = 16,
    parameter int unsigned   NUM_OUT = 8,
    localparam int unsigned  SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready
`ifdef STREAM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]      err_count
`endif
);

    // Pad per-channel vectors to the full select range so any in_sel indexes safely.
    localparam int unsigned NUM_PAD = 1 << SEL_W;

    logic               in_range;
    logic               xfer;
    logic [NUM_PAD-1:0] full_pad;
    logic [NUM_PAD-1:0] ready_pad;
    logic [NUM_OUT-1:0] wr_en;

    assign in_range  = (32'(in_sel) < NUM_OUT);
    assign full_pad  = NUM_PAD'(out_valid);
    assign ready_pad = NUM_PAD'(out_ready);
    assign in_ready  = !reset && (!in_range || !full_pad[in_sel] || ready_pad[in_sel]);
    assign xfer      = in_valid && in_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign wr_en[k] = xfer && in_range && (in_sel == SEL_W'(k));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef STREAM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (xfer && !in_range && (err_q != '1)) begin
            err_q <= err_q + ERRCNT_W'(1);
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus randomized traffic against a
// slot-level reference model, on an 8-channel and a 5-channel instance.
module tb_stream_demux;

    logic         clk;
    logic         reset;

    logic [15:0]  in_data8;
    logic [2:0]   in_sel8;
    logic         in_valid8, in_ready8;
    logic [127:0] out_data8;
    logic [7:0]   out_valid8, out_ready8;

    logic [15:0]  in_data5;
    logic [2:0]   in_sel5;
    logic         in_valid5, in_ready5;
    logic [79:0]  out_data5;
    logic [4:0]   out_valid5, out_ready5;
`ifdef STREAM_DEMUX_ERRCNT_EN
    logic [15:0]  err_count8, err_count5;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents of each channel's one-word buffer.
    bit          full8 [8];
    logic [15:0] data8 [8];
    bit          full5 [5];
    logic [15:0] data5 [5];
    int          err5;

    stream_demux #(.WIDTH(16), .NUM_OUT(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data8),
        .in_sel    (in_sel8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
`ifdef STREAM_DEMUX_ERRCNT_EN
        ,
        .err_count (err_count8)
`endif
    );

    stream_demux #(.WIDTH(16), .NUM_OUT(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data5),
        .in_sel    (in_sel5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
`ifdef STREAM_DEMUX_ERRCNT_EN
        ,
        .err_count (err_count5)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_ready8();
        return !reset && (!full8[in_sel8] || out_ready8[in_sel8]);
    endfunction

    function automatic logic exp_ready5();
        if (reset) return 1'b0;
        if (in_sel5 >= 3'd5) return 1'b1;
        return !full5[in_sel5] || out_ready5[in_sel5];
    endfunction

    function automatic logic [7:0] exp_vld8();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = full8[k];
        return v;
    endfunction

    function automatic logic [127:0] exp_dat8();
        logic [127:0] d;
        for (int k = 0; k < 8; k++) d[k*16 +: 16] = data8[k];
        return d;
    endfunction

    function automatic logic [4:0] exp_vld5();
        logic [4:0] v;
        for (int k = 0; k < 5; k++) v[k] = full5[k];
        return v;
    endfunction

    function automatic logic [79:0] exp_dat5();
        logic [79:0] d;
        for (int k = 0; k < 5; k++) d[k*16 +: 16] = data5[k];
        return d;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin full8[k] = 0; data8[k] = '0; end
        for (int k = 0; k < 5; k++) begin full5[k] = 0; data5[k] = '0; end
        err5 = 0;
    endtask

    // Advance one clock: apply spec transfer rules to the model, then wait past the edge.
    task automatic step();
        bit acc8, acc5;
        if (reset) begin
            model_clear();
        end else begin
            acc8 = in_valid8 && exp_ready8();
            acc5 = in_valid5 && exp_ready5();
            for (int k = 0; k < 8; k++) if (out_ready8[k]) full8[k] = 0;
            for (int k = 0; k < 5; k++) if (out_ready5[k]) full5[k] = 0;
            if (acc8) begin
                full8[in_sel8] = 1;
                data8[in_sel8] = in_data8;
            end
            if (acc5 && in_sel5 < 3'd5) begin
                full5[in_sel5] = 1;
                data5[in_sel5] = in_data5;
            end else if (acc5 && err5 < 65535) begin
                err5++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid8 = 0; in_sel8 = '0; in_data8 = '0; out_ready8 = '1;
        in_valid5 = 0; in_sel5 = '0; in_data5 = '0; out_ready5 = '1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) step();
        reset = 1'b0;
        step();
        // Fill slot 3 and leave it blocked, then reset asynchronously mid-cycle.
        out_ready8[3] = 0;
        in_valid8 = 1; in_sel8 = 3'd3; in_data8 = 16'h3333;
        step();
        in_valid8 = 0;
        n_cmp++;
        if (out_valid8 !== 8'h08) begin
            n_err++; $display("FAIL reset_prefill: out_valid %h want %h", out_valid8, 8'h08);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid8 !== 8'h00 || out_data8 !== 128'h0) begin
            n_err++; $display("FAIL reset_async: out_valid %h out_data %h want 0", out_valid8, out_data8);
        end
        n_cmp++;
        if (in_ready8 !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready8);
        end
`ifdef STREAM_DEMUX_ERRCNT_EN
        n_cmp++;
        if (err_count5 !== 16'h0) begin
            n_err++; $display("FAIL reset_errcnt: got %h want 0000", err_count5);
        end
`endif
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready8 = '1;
        step();
        n_cmp++;
        if (out_valid8 !== 8'h00) begin
            n_err++; $display("FAIL reset_release: out_valid %h want 00", out_valid8);
        end
    endtask

    task automatic test_sweep();
        out_ready8 = '1;
        for (int k = 0; k < 8; k++) begin
            in_valid8 = 1; in_sel8 = 3'(k); in_data8 = 16'hA000 + 16'(k);
            #1;
            n_cmp++;
            if (in_ready8 !== 1'b1) begin
                n_err++; $display("FAIL sweep_ready[%0d]: got %b want 1", k, in_ready8);
            end
            step();
            n_cmp++;
            if (out_valid8 !== (8'h01 << k) || out_data8[k*16 +: 16] !== 16'hA000 + 16'(k)) begin
                n_err++;
                $display("FAIL sweep[%0d]: valid %h data %h want %h %h", k, out_valid8,
                         out_data8[k*16 +: 16], 8'h01 << k, 16'hA000 + 16'(k));
            end
        end
        in_valid8 = 0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready8 = 8'hFB;
        in_valid8 = 1; in_sel8 = 3'd2; in_data8 = 16'h1111;
        #1;
        n_cmp++;
        if (in_ready8 !== 1'b1) begin
            n_err++; $display("FAIL bp_first_ready: got %b want 1", in_ready8);
        end
        step();
        in_data8 = 16'h2222;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (in_ready8 !== 1'b0 || out_data8[32 +: 16] !== 16'h1111 || out_valid8[2] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: ready %b data %h valid %b want 0 1111 1", c, in_ready8,
                         out_data8[32 +: 16], out_valid8[2]);
            end
            step();
        end
        out_ready8[2] = 1;
        #1;
        n_cmp++;
        if (in_ready8 !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready8);
        end
        step();
        in_valid8 = 0;
        n_cmp++;
        if (out_valid8[2] !== 1'b1 || out_data8[32 +: 16] !== 16'h2222) begin
            n_err++; $display("FAIL bp_second: valid %b data %h want 1 2222", out_valid8[2],
                              out_data8[32 +: 16]);
        end
        step();
    endtask

    task automatic test_refill();
        out_ready8 = 8'hDF;
        in_valid8 = 1; in_sel8 = 3'd5; in_data8 = 16'hBEEF;
        step();
        out_ready8[5] = 1; in_data8 = 16'hCAFE;
        #1;
        n_cmp++;
        if (in_ready8 !== 1'b1 || out_data8[80 +: 16] !== 16'hBEEF) begin
            n_err++; $display("FAIL refill_ready: ready %b data %h want 1 beef", in_ready8,
                              out_data8[80 +: 16]);
        end
        step();
        in_valid8 = 0;
        n_cmp++;
        if (out_valid8[5] !== 1'b1 || out_data8[80 +: 16] !== 16'hCAFE) begin
            n_err++; $display("FAIL refill_data: valid %b data %h want 1 cafe", out_valid8[5],
                              out_data8[80 +: 16]);
        end
        step();
    endtask

    task automatic test_parallel();
        out_ready8 = 8'hBE;
        in_valid8 = 1; in_sel8 = 3'd0; in_data8 = 16'h0D0D;
        step();
        in_sel8 = 3'd6; in_data8 = 16'h6666;
        #1;
        n_cmp++;
        if (in_ready8 !== 1'b1) begin
            n_err++; $display("FAIL parallel_ready: got %b want 1", in_ready8);
        end
        step();
        in_valid8 = 0;
        n_cmp++;
        if (out_valid8 !== 8'h41 || out_data8[0 +: 16] !== 16'h0D0D || out_data8[96 +: 16] !== 16'h6666)
        begin
            n_err++; $display("FAIL parallel: valid %h d0 %h d6 %h want 41 0d0d 6666", out_valid8,
                              out_data8[0 +: 16], out_data8[96 +: 16]);
        end
        out_ready8 = '1;
        step();
    endtask

    task automatic test_out_of_range();
        // Park a word in slot 1 so "no slot changes" is observable.
        out_ready5 = 5'b11101;
        in_valid5 = 1; in_sel5 = 3'd1; in_data5 = 16'h5151;
        step();
        for (int i = 0; i < 3; i++) begin
            in_sel5 = 3'd5 + 3'(i); in_data5 = 16'hE000 + 16'(i);
            #1;
            n_cmp++;
            if (in_ready5 !== 1'b1) begin
                n_err++; $display("FAIL oor_ready[%0d]: got %b want 1", i, in_ready5);
            end
            step();
            n_cmp++;
            if (out_valid5 !== 5'b00010 || out_data5 !== exp_dat5()) begin
                n_err++; $display("FAIL oor_nochange[%0d]: valid %h data %h want 02 %h", i,
                                  out_valid5, out_data5, exp_dat5());
            end
        end
        in_valid5 = 0;
`ifdef STREAM_DEMUX_ERRCNT_EN
        n_cmp++;
        if (err_count5 !== 16'd3) begin
            n_err++; $display("FAIL errcnt_three: got %0d want 3", err_count5);
        end
        in_valid5 = 1; in_sel5 = 3'd7;
        repeat (65532) step();
        n_cmp++;
        if (err_count5 !== 16'hFFFF) begin
            n_err++; $display("FAIL errcnt_reach_max: got %h want ffff", err_count5);
        end
        repeat (2) step();
        n_cmp++;
        if (err_count5 !== 16'hFFFF) begin
            n_err++; $display("FAIL errcnt_saturate: got %h want ffff", err_count5);
        end
        in_valid5 = 0;
`endif
        out_ready5 = '1;
        step();
    endtask

    task automatic test_random();
        bit hold8 = 0, hold5 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!hold8) begin
                in_valid8 = 1'($urandom_range(0, 3) != 0);
                in_sel8   = 3'($urandom_range(0, 7));
                in_data8  = 16'($urandom);
            end
            if (!hold5) begin
                in_valid5 = 1'($urandom_range(0, 3) != 0);
                in_sel5   = 3'($urandom_range(0, 7));
                in_data5  = 16'($urandom);
            end
            out_ready8 = 8'($urandom);
            out_ready5 = 5'($urandom);
            #1;
            n_cmp++;
            if (in_ready8 !== exp_ready8() || in_ready5 !== exp_ready5()) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b/%b want %b/%b", c, in_ready8,
                                  in_ready5, exp_ready8(), exp_ready5());
            end
            hold8 = in_valid8 && !exp_ready8();
            hold5 = in_valid5 && !exp_ready5();
            step();
            n_cmp++;
            if (out_valid8 !== exp_vld8() || out_data8 !== exp_dat8()) begin
                n_err++; $display("FAIL rand_out8[%0d]: valid %h data %h want %h %h", c,
                                  out_valid8, out_data8, exp_vld8(), exp_dat8());
            end
            n_cmp++;
            if (out_valid5 !== exp_vld5() || out_data5 !== exp_dat5()) begin
                n_err++; $display("FAIL rand_out5[%0d]: valid %h data %h want %h %h", c,
                                  out_valid5, out_data5, exp_vld5(), exp_dat5());
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_refill();
        test_parallel();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
